// File: rtl/wb_queue.sv
// wb_queue: writeback FIFO between the ALU / mul-div result paths
// and the register file write port, with pending-write lookup.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [AW-1:0]            a_addr,
  input  logic [WIDTH-1:0]         a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_addr,
  input  logic [WIDTH-1:0]         b_data,
  input  logic                     hold,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [WIDTH-1:0]         wd3,
  input  logic [AW-1:0]            qa1,
  input  logic [AW-1:0]            qa2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULLC = (PW+1)'(DEPTH);

  logic [AW-1:0]    ma [DEPTH];
  logic [WIDTH-1:0] md [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  logic             acc_a;
  logic             acc_b;
  logic             enq;
  logic             deq;
  logic [AW-1:0]    enq_addr;
  logic [WIDTH-1:0] enq_data;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  assign empty = (count == '0);
  assign full  = (count == FULLC);

  assign a_ready = !full;
  assign b_ready = !full && !a_valid;

  assign acc_a = a_valid && a_ready;
  assign acc_b = b_valid && b_ready;

  // Pick the accepted producer; A and B never both win.
  always_comb begin
    enq_addr = '0;
    enq_data = '0;
    unique case (1'b1)
      acc_a: begin
        enq_addr = a_addr;
        enq_data = a_data;
      end
      acc_b: begin
        enq_addr = b_addr;
        enq_data = b_data;
      end
      default: ;
    endcase
  end

  // r0 results complete the handshake but are dropped.
  assign enq = (acc_a || acc_b) && (enq_addr != '0);

  assign we3 = !empty && !hold;
  assign deq = we3;
  assign wa3 = empty ? '0 : ma[rptr];
  assign wd3 = empty ? '0 : md[rptr];

  // An entry is live if it sits within count slots of the head.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] off;
    logic          occ;
    assign off     = PW'(i) - rptr;
    assign occ     = {1'b0, off} < count;
    assign hit1[i] = occ && (ma[i] == qa1);
    assign hit2[i] = occ && (ma[i] == qa2);
  end

  assign busy1 = (qa1 != '0) && (|hit1);
  assign busy2 = (qa2 != '0) && (|hit2);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      if (enq && !deq)
        count <= count + (PW+1)'(1);
      else if (!enq && deq)
        count <= count - (PW+1)'(1);
    end
  end

  // Entry storage; contents are irrelevant outside the live window.
  always_ff @(posedge clk) begin
    if (enq) begin
      ma[wptr] <= enq_addr;
      md[wptr] <= enq_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized + directed bench for wb_queue
// with a queue-based reference model and write scoreboard.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid;
  logic             a_ready;
  logic [AW-1:0]    a_addr;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_data;
  logic             hold;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic [AW-1:0]    qa1;
  logic [AW-1:0]    qa2;
  logic             busy1;
  logic             busy2;
  logic [2:0]       count;
  logic             empty;
  logic             full;

  ent_t mq[$];
  ent_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data),
    .hold(hold),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .qa1(qa1), .qa2(qa2),
    .busy1(busy1), .busy2(busy2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit mbusy(input logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == q) return 1'b1;
    return 1'b0;
  endfunction

  // Write monitor: every register-file write must match the oldest
  // expected result.
  always @(negedge clk) begin
    if (we3) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: wa3=%0d wd3=0x%0h, none pending",
                 wa3, wd3);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("wa3", 32'(wa3), 32'(e.a));
        chk("wd3", wd3, e.d);
      end
    end
  end

  task automatic check_outputs();
    int sz;
    bit ef;
    sz = mq.size();
    ef = (sz == DEPTH);
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(ef));
    chk("a_ready", 32'(a_ready), 32'(!ef));
    chk("b_ready", 32'(b_ready), 32'(!ef && !a_valid));
    chk("we3", 32'(we3), 32'(sz > 0 && !hold));
    chk("busy1", 32'(busy1), 32'(mbusy(qa1)));
    chk("busy2", 32'(busy2), 32'(mbusy(qa2)));
    if (sz == 0) begin
      chk("wa3_idle", 32'(wa3), 32'd0);
      chk("wd3_idle", wd3, 32'd0);
    end
  endtask

  task automatic model_edge();
    int sz;
    bit aa;
    bit bb;
    ent_t e;
    sz = mq.size();
    if (!reset) begin
      mq.delete();
      sb.delete();
      return;
    end
    aa = a_valid && (sz < DEPTH);
    bb = b_valid && !a_valid && (sz < DEPTH);
    if (sz > 0 && !hold) void'(mq.pop_front());
    if (aa && a_addr != 0) begin
      e.a = a_addr;
      e.d = a_data;
      mq.push_back(e);
      sb.push_back(e);
    end else if (bb && b_addr != 0) begin
      e.a = b_addr;
      e.d = b_data;
      mq.push_back(e);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [AW-1:0] ad,
                       input logic [WIDTH-1:0] d);
    a_valid = v;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic drv_b(input logic v, input logic [AW-1:0] ad,
                       input logic [WIDTH-1:0] d);
    b_valid = v;
    b_addr  = ad;
    b_data  = d;
  endtask

  task automatic idle(input int n);
    drv_a(1'b0, '0, '0);
    drv_b(1'b0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    qa1   = 5'd5;
    qa2   = 5'd0;
    drv_a(1'b1, 5'd5, 32'h1234);
    drv_b(1'b1, 5'd6, 32'h5678);

    // Held in reset with offers present: nothing is accepted.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    idle(3);

    // Single write and busy tracking.
    qa1 = 5'd5;
    drv_a(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    idle(3);

    // Contention: A wins, B follows.
    qa1 = 5'd3;
    qa2 = 5'd4;
    drv_a(1'b1, 5'd3, 32'd1);
    drv_b(1'b1, 5'd4, 32'd2);
    step();
    drv_a(1'b0, '0, '0);
    step();
    idle(3);

    // Backpressure: fill under hold, refused 5th offer, then drain.
    hold = 1'b1;
    qa1  = 5'd2;
    qa2  = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      drv_a(1'b1, 5'(i), 32'(16 * i));
      step();
    end
    drv_a(1'b1, 5'd5, 32'h50);
    step();
    step();
    hold = 1'b0;
    drv_a(1'b0, '0, '0);
    idle(6);

    // r0 results are dropped.
    qa1 = 5'd0;
    drv_a(1'b1, 5'd0, 32'hFFFF);
    step();
    drv_a(1'b0, '0, '0);
    drv_b(1'b1, 5'd0, 32'hAAAA);
    step();
    idle(2);
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv_a(1'b1, 5'(i + 8), 32'(i));
      step();
    end
    idle(2);
    hold = 1'b0;
    idle(6);

    // Reset pulse between edges drops three pending entries.
    hold = 1'b1;
    qa1  = 5'd7;
    qa2  = 5'd8;
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b1, 5'(7 + i), 32'(100 + i));
      step();
    end
    drv_a(1'b0, '0, '0);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    mq.delete();
    sb.delete();
    #1;
    reset = 1'b1;
    hold  = 1'b0;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drv_a($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)),
            $urandom);
      drv_b($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
            $urandom);
      hold = ($urandom_range(0, 99) < 30);
      qa1  = 5'($urandom_range(0, 7));
      qa2  = 5'($urandom_range(0, 7));
      step();
    end

    hold = 1'b0;
    idle(8);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
